// File: rtl/uart_pkg.sv
// Shared UART definitions: line-level bit values, FSM state encodings and the
// baud divisor helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic StartBit = 1'b0;
  localparam logic StopBit  = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  function automatic int unsigned calc_bit_ticks(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter: counts 0..Ticks-1, wraps, and flags the
// final cycle of each bit period. Held at zero while clear is high.
module uart_baud_tick #(
  parameter int unsigned Ticks = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic last
);

  localparam logic [15:0] LastCnt = 16'(Ticks - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign last = (cnt_q == LastCnt);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register so that a queued
// byte is launched straight out of the stop bit with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data_i,
  input  logic       tx_data_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BitTicks = calc_bit_ticks(CLK_FREQ, BAUD_RATE);

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  hold_data_q;
  logic        hold_valid_q;
  logic        hold_valid_d;
  logic        tx_ready_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic        bit_last;
  logic        accept;
  logic        load;

  uart_baud_tick #(
    .Ticks(BitTicks)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == StIdle),
    .last (bit_last)
  );

  // A held byte is launched from idle or straight out of the final stop cycle.
  always_comb begin
    accept       = tx_data_valid && tx_ready_q;
    load         = hold_valid_q && ((state_q == StIdle) || ((state_q == StStop) && bit_last));
    hold_valid_d = accept || (hold_valid_q && !load);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      tx_ready_q   <= 1'b1;
    end else begin
      hold_valid_q <= hold_valid_d;
      tx_ready_q   <= !hold_valid_d;
      if (accept) begin
        hold_data_q <= tx_data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= StopBit;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          tx_q <= StopBit;
          if (load) begin
            state_q <= StStart;
            shift_q <= hold_data_q;
            tx_q    <= StartBit;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (bit_last) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        StData: begin
          if (bit_last) begin
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= StopBit;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        StStop: begin
          if (bit_last) begin
            done_q <= 1'b1;
            if (load) begin
              state_q <= StStart;
              shift_q <= hold_data_q;
              tx_q    <= StartBit;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= StopBit;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule
